microsequencer: RTL and testbench

Next-state sequencer for the microprogrammed control unit.
- Holds the 7-bit control-state register that addresses the microstore.
- Each cycle, takes the sequencing fields from the current microinstruction and selects the next state: dispatch, increment, jump, conditional branch, wait, call or return.
- Sits between the instruction encoder, the condition tester and the microstore; this is the only sequential element in the control loop.

---
 rtl/microseq_pkg.sv | 41 ++++
 rtl/microseq_stack.sv | 72 +++++++
 rtl/microsequencer.sv | 168 ++++++++++++++++
 tb/tb_microsequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// -----------------------------------------------------------------------------
// microseq_pkg
//   Shared definitions for the microprogrammed control-unit sequencer:
//   control-state width, reset/fallback states, sequencing op encodings
//   (n_sel field of the microinstruction) and the bit positions inside the
//   cond_in vector delivered by the condition tester.
// -----------------------------------------------------------------------------
package microseq_pkg;

   // Width of a control-state address (microstore address).
   localparam int STATE_W = 7;

   // State loaded on reset, and the fetch state used as the fallback for
   // invalid dispatch, reserved op, stack underflow and wait timeout.
   localparam logic [STATE_W-1:0] RESET_STATE   = 7'd0;
   localparam logic [STATE_W-1:0] DEFAULT_STATE = 7'd1;

   // Sequencing op carried in the n_sel field.
   typedef enum logic [2:0] {
      OP_DISPATCH = 3'b000,
      OP_INCR     = 3'b001,
      OP_JUMP     = 3'b010,
      OP_BRANCH   = 3'b011,
      OP_WAIT     = 3'b100,
      OP_CALL     = 3'b101,
      OP_RETURN   = 3'b110,
      OP_RSVD     = 3'b111
   } seq_op_e;

   // Bit indices inside cond_in.
   localparam int COND_MOC  = 0;  // memory operation complete
   localparam int COND_Z    = 1;  // zero flag
   localparam int COND_N    = 2;  // negative flag
   localparam int COND_COND = 3;  // condition-tester result

   // Sequential successor of a control state; wraps at 2^STATE_W.
   function automatic logic [STATE_W-1:0] state_inc(input logic [STATE_W-1:0] s);
      return s + 1'b1;
   endfunction

endpackage

// File: rtl/microseq_stack.sv
// -----------------------------------------------------------------------------
// microseq_stack
//   Return-address LIFO for microcode subroutine calls.
//
//   Ports:
//     clk        in   rising-edge clock
//     reset      in   asynchronous active-low reset (empties the stack)
//     push       in   write push_data on top, depth increments
//     pop        in   discard top entry, depth decrements
//     push_data  in   [W-1:0] value to push
//     top_data   out  [W-1:0] current top entry (valid when !empty)
//     full       out  depth == DEPTH
//     empty      out  depth == 0
//     depth      out  [DEPTH_W-1:0] number of occupied entries
//
//   The parent never pushes when full, never pops when empty, and never
//   asserts push and pop together; no protection is built in here.
// -----------------------------------------------------------------------------
module microseq_stack #(
   parameter  int DEPTH   = 4,
   parameter  int W       = 7,
   localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [W-1:0]       push_data,
   output logic [W-1:0]       top_data,
   output logic               full,
   output logic               empty,
   output logic [DEPTH_W-1:0] depth
);

   logic [W-1:0]       mem [DEPTH];
   logic [DEPTH_W-1:0] depth_q;

   // Entry storage carries no reset: contents above depth are don't-care.
   // Entry i is written when the stack currently holds exactly i entries.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (depth_q == DEPTH_W'(i))) begin
            mem[i] <= push_data;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         depth_q <= '0;
      end else if (push) begin
         depth_q <= depth_q + 1'b1;
      end else if (pop) begin
         depth_q <= depth_q - 1'b1;
      end
   end

   // Top of stack is entry depth-1.
   always_comb begin
      top_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (depth_q == DEPTH_W'(i + 1)) begin
            top_data = mem[i];
         end
      end
   end

   assign full  = (depth_q == DEPTH_W'(DEPTH));
   assign empty = (depth_q == '0);
   assign depth = depth_q;

endmodule

// File: rtl/microsequencer.sv
// -----------------------------------------------------------------------------
// microsequencer
//   Next-state sequencer of the microprogrammed control unit. Holds the
//   control-state register that addresses the (combinational) microstore and,
//   every cycle, selects the next state from the sequencing fields of the
//   current microinstruction: dispatch, increment, jump, conditional branch,
//   wait, call or return.
//
//   Ports:
//     clk          in   rising-edge clock
//     reset        in   asynchronous active-low reset
//     n_sel        in   [2:0] sequencing op (seq_op_e)
//     inv          in   invert the selected condition
//     cond_sel     in   [1:0] selects one bit of cond_in
//     cond_in      in   [3:0] {COND, N, Z, MOC}
//     cr           in   [STATE_W-1:0] jump/branch/call target
//     enc_state    in   [STATE_W-1:0] encoder dispatch target
//     enc_valid    in   encoder recognised the instruction
//     stall        in   freeze every register (state, stack, counter, flags)
//     state        out  [STATE_W-1:0] current control state
//     wait_active  out  current op is WAIT and its condition is false
//     stack_depth  out  [2:0] occupied return-stack entries
//     stack_err    out  sticky: call on full stack or return on empty stack
//     timeout      out  sticky: a WAIT reached its cycle limit
//
//   The n_sel/cr/cond fields belong to the current state, so the selected
//   next state appears one clock later. The state register is the sequencer's
//   only state machine and is exposed directly on the state output.
// -----------------------------------------------------------------------------
module microsequencer
   import microseq_pkg::*;
#(
   parameter int STACK_DEPTH = 4,
   parameter int WAIT_LIMIT  = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         n_sel,
   input  logic               inv,
   input  logic [1:0]         cond_sel,
   input  logic [3:0]         cond_in,
   input  logic [STATE_W-1:0] cr,
   input  logic [STATE_W-1:0] enc_state,
   input  logic               enc_valid,
   input  logic               stall,
   output logic [STATE_W-1:0] state,
   output logic               wait_active,
   output logic [2:0]         stack_depth,
   output logic               stack_err,
   output logic               timeout
);

   localparam int CNT_W   = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   // Registered state
   logic [STATE_W-1:0] state_q;
   logic [CNT_W-1:0]   wait_cnt_q;
   logic               stack_err_q;
   logic               timeout_q;

   // Combinational next-state decisions
   logic               t;
   logic [STATE_W-1:0] inc;
   logic [STATE_W-1:0] state_d;
   logic [CNT_W-1:0]   wait_cnt_d;
   logic               push_req;
   logic               pop_req;
   logic               set_stack_err;
   logic               set_timeout;

   // Stack interface
   logic [STATE_W-1:0] stk_top;
   logic               stk_full;
   logic               stk_empty;
   logic [DEPTH_W-1:0] stk_depth;

   assign t   = cond_in[cond_sel] ^ inv;
   assign inc = state_inc(state_q);

   // Next-state selection. The wait counter defaults to zero, so it clears on
   // every cycle that does not hold in WAIT.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = '0;
      push_req      = 1'b0;
      pop_req       = 1'b0;
      set_stack_err = 1'b0;
      set_timeout   = 1'b0;

      case (n_sel)
         OP_DISPATCH: state_d = enc_valid ? enc_state : DEFAULT_STATE;
         OP_INCR:     state_d = inc;
         OP_JUMP:     state_d = cr;
         OP_BRANCH:   state_d = t ? cr : inc;
         OP_WAIT: begin
            if (t) begin
               state_d = inc;
            end else if (wait_cnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
               // Waited too long: give up and go back to fetch.
               state_d     = DEFAULT_STATE;
               set_timeout = 1'b1;
            end else begin
               state_d    = state_q;
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         OP_CALL: begin
            // The jump happens even when the return address cannot be saved.
            state_d = cr;
            if (stk_full) begin
               set_stack_err = 1'b1;
            end else begin
               push_req = 1'b1;
            end
         end
         OP_RETURN: begin
            if (stk_empty) begin
               state_d       = DEFAULT_STATE;
               set_stack_err = 1'b1;
            end else begin
               state_d = stk_top;
               pop_req = 1'b1;
            end
         end
         default: state_d = DEFAULT_STATE;  // reserved op
      endcase
   end

   // stall freezes every register, so it simply gates all updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RESET_STATE;
         wait_cnt_q  <= '0;
         stack_err_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else if (!stall) begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stack_err_q <= stack_err_q | set_stack_err;
         timeout_q   <= timeout_q | set_timeout;
      end
   end

   microseq_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (STATE_W)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req && !stall),
      .pop       (pop_req && !stall),
      .push_data (inc),
      .top_data  (stk_top),
      .full      (stk_full),
      .empty     (stk_empty),
      .depth     (stk_depth)
   );

   // Combinational and deliberately not gated by stall.
   assign wait_active = (n_sel == OP_WAIT) && !t;

   assign state       = state_q;
   assign stack_depth = 3'(stk_depth);
   assign stack_err   = stack_err_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_microsequencer.sv
// -----------------------------------------------------------------------------
// tb_microsequencer
//   Directed bench for the microsequencer: reset, dispatch, branch, increment
//   wrap, wait/timeout, call/return stack and stall behaviour. Inputs change
//   one time unit after the rising edge; outputs are observed there too.
// -----------------------------------------------------------------------------
module tb_microsequencer;
   import microseq_pkg::*;

   // Clock / reset
   logic               clk = 1'b0;
   logic               reset;
   always #5 clk = ~clk;

   // DUT signals
   logic [2:0]         n_sel;
   logic               inv;
   logic [1:0]         cond_sel;
   logic [3:0]         cond_in;
   logic [STATE_W-1:0] cr;
   logic [STATE_W-1:0] enc_state;
   logic               enc_valid;
   logic               stall;
   logic [STATE_W-1:0] state;
   logic               wait_active;
   logic [2:0]         stack_depth;
   logic               stack_err;
   logic               timeout;

   microsequencer #(
      .STACK_DEPTH (4),
      .WAIT_LIMIT  (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .n_sel       (n_sel),
      .inv         (inv),
      .cond_sel    (cond_sel),
      .cond_in     (cond_in),
      .cr          (cr),
      .enc_state   (enc_state),
      .enc_valid   (enc_valid),
      .stall       (stall),
      .state       (state),
      .wait_active (wait_active),
      .stack_depth (stack_depth),
      .stack_err   (stack_err),
      .timeout     (timeout)
   );

   // Scoreboard
   int                 n_checks = 0;
   int                 n_fail   = 0;
   logic [STATE_W-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [STATE_W-1:0] tgt,
                        input logic [1:0] sel, input logic [3:0] cin, input logic iv);
      n_sel    = op;
      cr       = tgt;
      cond_sel = sel;
      cond_in  = cin;
      inv      = iv;
      #1;
   endtask

   task automatic goto_state(input logic [STATE_W-1:0] s);
      drive(OP_JUMP, s, 2'd0, 4'd0, 1'b0);
      tick();
   endtask

   // Watchdog: the run is a few hundred cycles.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      n_sel     = OP_INCR;
      inv       = 1'b0;
      cond_sel  = 2'd0;
      cond_in   = 4'd0;
      cr        = '0;
      enc_state = '0;
      enc_valid = 1'b0;
      stall     = 1'b0;

      // ---------------- reset ----------------
      tick();
      tick();
      check("rst_state", state, 0);
      check("rst_depth", stack_depth, 0);
      check("rst_err", stack_err, 0);
      check("rst_timeout", timeout, 0);
      reset = 1'b1;

      // RETURN on empty stack -> fetch, stack_err
      drive(OP_RETURN, 7'd0, 2'd0, 4'd0, 1'b0);
      tick();
      check("ret_empty_state", state, 1);
      check("ret_empty_err", stack_err, 1);
      check("ret_empty_depth", stack_depth, 0);

      // CALL to 9, then WAIT at 9 with MOC low
      drive(OP_CALL, 7'd9, 2'd0, 4'd0, 1'b0);
      tick();
      check("pre_rst_state", state, 9);
      check("pre_rst_depth", stack_depth, 1);
      drive(OP_WAIT, 7'd0, 2'd0, 4'd0, 1'b0);
      check("pre_rst_wait_active", wait_active, 1);
      tick();
      tick();
      check("pre_rst_hold", state, 9);

      // Asynchronous reset in the middle of the cycle
      #2 reset = 1'b0;
      #1;
      check("async_rst_state", state, 0);
      check("async_rst_depth", stack_depth, 0);
      check("async_rst_err", stack_err, 0);
      check("async_rst_timeout", timeout, 0);
      #1 reset = 1'b1;
      drive(OP_INCR, 7'd0, 2'd0, 4'd0, 1'b0);
      tick();
      check("post_rst_incr", state, 1);

      // ---------------- dispatch / reserved ----------------
      enc_valid = 1'b1;
      enc_state = 7'd12;
      drive(OP_DISPATCH, 7'd0, 2'd0, 4'd0, 1'b0);
      tick();
      check("dispatch_valid", state, 12);
      enc_valid = 1'b0;
      tick();
      check("dispatch_invalid", state, 1);
      goto_state(7'd50);
      drive(OP_RSVD, 7'd99, 2'd0, 4'd0, 1'b0);
      tick();
      check("reserved_op", state, 1);

      // ---------------- branch ----------------
      goto_state(7'd5);
      drive(OP_BRANCH, 7'd40, 2'd1, 4'b0010, 1'b0);
      tick();
      check("branch_z_taken", state, 40);
      goto_state(7'd5);
      drive(OP_BRANCH, 7'd40, 2'd1, 4'b0010, 1'b1);
      tick();
      check("branch_z_inv", state, 6);
      goto_state(7'd5);
      drive(OP_BRANCH, 7'd40, 2'd3, 4'b0111, 1'b0);
      tick();
      check("branch_cond_not_taken", state, 6);
      goto_state(7'd5);
      drive(OP_BRANCH, 7'd33, 2'd2, 4'b0100, 1'b0);
      tick();
      check("branch_n_taken", state, 33);

      // ---------------- increment wrap ----------------
      goto_state(7'd127);
      drive(OP_INCR, 7'd0, 2'd0, 4'd0, 1'b0);
      tick();
      check("incr_wrap", state, 0);

      // ---------------- wait: MOC arrives ----------------
      goto_state(7'd7);
      drive(OP_WAIT, 7'd0, 2'd0, 4'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         check("wait_active_held", wait_active, 1);
         tick();
         check("wait_hold", state, 7);
      end
      drive(OP_WAIT, 7'd0, 2'd0, 4'b0001, 1'b0);
      check("wait_active_moc", wait_active, 0);
      tick();
      check("wait_release", state, 8);

      // ---------------- wait: timeout ----------------
      goto_state(7'd7);
      drive(OP_WAIT, 7'd0, 2'd0, 4'd0, 1'b0);
      repeat (63) tick();
      check("timeout_hold63", state, 7);
      check("timeout_not_yet", timeout, 0);
      tick();
      check("timeout_state", state, 1);
      check("timeout_flag", timeout, 1);

      // ---------------- stall during wait ----------------
      goto_state(7'd7);
      drive(OP_WAIT, 7'd0, 2'd0, 4'd0, 1'b0);
      repeat (10) tick();
      stall = 1'b1;
      repeat (5) tick();
      check("stall_wait_state", state, 7);
      check("stall_wait_active", wait_active, 1);
      stall = 1'b0;
      repeat (53) tick();
      check("stall_wait_cnt_frozen", state, 7);
      tick();
      check("stall_wait_timeout", state, 1);

      // ---------------- call / return ----------------
      goto_state(7'd20);
      drive(OP_CALL, 7'd30, 2'd0, 4'd0, 1'b0);
      tick();
      check("call_state", state, 30);
      check("call_depth", stack_depth, 1);
      drive(OP_RETURN, 7'd0, 2'd0, 4'd0, 1'b0);
      tick();
      check("return_state", state, 21);
      check("return_depth", stack_depth, 0);

      // Five nested calls from 10: 10->20->30->40->50->60
      goto_state(7'd10);
      for (int i = 0; i < 4; i++) begin
         drive(OP_CALL, 7'(20 + 10 * i), 2'd0, 4'd0, 1'b0);
         tick();
         exp_q.push_back(7'(11 + 10 * i));
      end
      check("nest4_depth", stack_depth, 4);
      check("nest4_no_err", stack_err, 0);
      drive(OP_CALL, 7'd60, 2'd0, 4'd0, 1'b0);
      tick();
      check("overflow_jump", state, 60);
      check("overflow_depth", stack_depth, 4);
      check("overflow_err", stack_err, 1);
      drive(OP_RETURN, 7'd0, 2'd0, 4'd0, 1'b0);
      while (exp_q.size() > 0) begin
         tick();
         check("nest_return", state, exp_q.pop_back());
      end
      check("nest_empty_depth", stack_depth, 0);
      tick();
      check("underflow_state", state, 1);
      check("underflow_err", stack_err, 1);

      // ---------------- stall during call ----------------
      goto_state(7'd70);
      stall = 1'b1;
      drive(OP_CALL, 7'd80, 2'd0, 4'd0, 1'b0);
      repeat (2) tick();
      check("stall_call_state", state, 70);
      check("stall_call_depth", stack_depth, 0);
      stall = 1'b0;
      tick();
      check("call_after_stall_state", state, 80);
      check("call_after_stall_depth", stack_depth, 1);
      drive(OP_RETURN, 7'd0, 2'd0, 4'd0, 1'b0);
      tick();
      check("return_after_stall", state, 71);

      // Final report
      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
